// File: rtl/lsu_bus_if.sv
// -----------------------------------------------------------------------------
// lsu_bus_if : request/grant/response bus between the load/store unit and the
//              data RAM.
//
//   bus_req    master -> slave  request valid; address/controls stable while high
//   bus_we     master -> slave  1 = write
//   bus_sel    master -> slave  byte lanes
//   bus_addr   master -> slave  word-aligned address
//   bus_wdata  master -> slave  write data
//   bus_gnt    slave  -> master request accepted this cycle
//   bus_rvalid slave  -> master response valid (loads and stores)
//   bus_rdata  slave  -> master response data
//   bus_err    slave  -> master response error, qualified by bus_rvalid
//
// Handshake: a request transfers on the rising edge where bus_req and bus_gnt
// are both high; until then the master holds every bus_* output stable. Exactly
// one response (bus_rvalid high for one cycle) follows each accepted request,
// no earlier than the grant cycle itself. bus_rvalid is only meaningful after
// a grant; the master ignores it at any other time.
// -----------------------------------------------------------------------------
interface lsu_bus_if;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        bus_err;

  modport master (
    output bus_req, bus_we, bus_sel, bus_addr, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata, bus_err
  );

  modport slave (
    input  bus_req, bus_we, bus_sel, bus_addr, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata, bus_err
  );
endinterface

// File: rtl/lsu.sv
// -----------------------------------------------------------------------------
// lsu : load/store unit sitting right after the execute stage.
//
// Takes one memory request from execute, runs it on the data RAM bus
// (request -> grant -> response), aligns/extends load data and drives the
// register write-back port. Non-memory results pass through with one register
// stage. stall_req holds the pipeline while a transaction is outstanding.
//
// Ports
//   clk, rst          clock; asynchronous active-low reset
//   ex_*              memory request and non-memory result from execute
//   bus               data RAM bus (lsu_bus_if.master)
//   wb_waddr/wdata/we register write-back, registered
//   stall_req         combinational pipeline hold
//   exc_misalign      one-cycle pulse, misaligned access
//   exc_bus_err       one-cycle pulse, bus error or timeout
//   exc_addr          faulting address, valid with either exception pulse
//   o_dbg_state       current FSM state (0 IDLE, 1 REQ, 2 WAIT, 3 DONE)
// -----------------------------------------------------------------------------
module lsu #(
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_req,
  input  logic             ex_we,
  input  logic [2:0]       ex_funct3,
  input  logic [31:0]      ex_addr,
  input  logic [3:0]       ex_sel,
  input  logic [31:0]      ex_wdata,
  input  logic [4:0]       ex_waddr,
  input  logic             ex_reg_we,
  input  logic [31:0]      ex_result,
  lsu_bus_if.master        bus,
  output logic [4:0]       wb_waddr,
  output logic [31:0]      wb_wdata,
  output logic             wb_we,
  output logic             stall_req,
  output logic             exc_misalign,
  output logic             exc_bus_err,
  output logic [31:0]      exc_addr,
  output logic [1:0]       o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Last counter value still inside the allowed window; counter starts at 0
  // on entry to REQ, so TIMEOUT cycles elapse when it sits at TIMEOUT-1.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_nxt;

  // Captured request
  logic [31:0] r_addr;
  logic [2:0]  r_funct3;
  logic        r_we;
  logic [3:0]  r_sel;
  logic [31:0] r_wdata;
  logic [4:0]  r_waddr;
  logic        r_reg_we;
  logic        w_capture;

  // Next values of the registered outputs
  logic [4:0]  w_wb_waddr_nxt;
  logic [31:0] w_wb_wdata_nxt;
  logic        w_wb_we_nxt;
  logic        w_exc_mis_nxt;
  logic        w_exc_bus_nxt;
  logic [31:0] w_exc_addr_nxt;

  logic        w_misalign;
  logic        w_in_req;
  logic        w_busy;
  logic        w_resp;
  logic        w_tmo;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ld_data;
  logic        w_ld_ok;

  // Halfword: funct3[1:0]=01 (LH/LHU/SH). Word: funct3=010 (LW/SW).
  assign w_misalign = ((ex_funct3[1:0] == 2'b01) && ex_addr[0]) ||
                      ((ex_funct3 == 3'b010) && (ex_addr[1:0] != 2'b00));

  assign w_in_req = (r_state == S_REQ);
  assign w_busy   = (r_state == S_REQ) || (r_state == S_WAIT);

  // A response counts in REQ only when the grant lands in the same cycle;
  // an rvalid without a prior grant is not ours.
  assign w_resp = (w_in_req && bus.bus_gnt && bus.bus_rvalid) ||
                  ((r_state == S_WAIT) && bus.bus_rvalid);
  assign w_tmo  = w_busy && (r_cnt == TMO_LAST);

  // Bus outputs are only driven while requesting so they read 0 otherwise.
  assign bus.bus_req   = w_in_req;
  assign bus.bus_we    = w_in_req & r_we;
  assign bus.bus_sel   = w_in_req ? r_sel : 4'b0000;
  assign bus.bus_addr  = w_in_req ? {r_addr[31:2], 2'b00} : 32'h0;
  assign bus.bus_wdata = w_in_req ? r_wdata : 32'h0;

  assign stall_req   = w_busy || ((r_state == S_IDLE) && ex_req);
  assign o_dbg_state = r_state;

  // Load data alignment and extension
  always_comb begin
    w_byte = bus.bus_rdata[7:0];
    case (r_addr[1:0])
      2'd0:    w_byte = bus.bus_rdata[7:0];
      2'd1:    w_byte = bus.bus_rdata[15:8];
      2'd2:    w_byte = bus.bus_rdata[23:16];
      default: w_byte = bus.bus_rdata[31:24];
    endcase
    w_half = r_addr[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];

    w_ld_ok   = 1'b1;
    w_ld_data = 32'h0;
    case (r_funct3)
      3'b000:  w_ld_data = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ld_data = {{16{w_half[15]}}, w_half};
      3'b010:  w_ld_data = bus.bus_rdata;
      3'b100:  w_ld_data = {24'h0, w_byte};
      3'b101:  w_ld_data = {16'h0, w_half};
      default: w_ld_ok   = 1'b0;
    endcase
  end

  // Next state and registered-output values
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_capture      = 1'b0;
    w_wb_waddr_nxt = wb_waddr;
    w_wb_wdata_nxt = wb_wdata;
    w_wb_we_nxt    = 1'b0;
    w_exc_mis_nxt  = 1'b0;
    w_exc_bus_nxt  = 1'b0;
    w_exc_addr_nxt = exc_addr;

    case (r_state)
      S_IDLE: begin
        if (!ex_req) begin
          w_wb_waddr_nxt = ex_waddr;
          w_wb_wdata_nxt = ex_result;
          w_wb_we_nxt    = ex_reg_we;
        end else begin
          w_capture = 1'b1;
          if (w_misalign) begin
            w_state_nxt    = S_DONE;
            w_exc_mis_nxt  = 1'b1;
            w_exc_addr_nxt = ex_addr;
          end else begin
            w_state_nxt = S_REQ;
            w_cnt_nxt   = 8'd0;
          end
        end
      end

      S_REQ, S_WAIT: begin
        w_cnt_nxt = r_cnt + 8'd1;
        // Response is checked before the timeout so a last-cycle rvalid wins.
        if (w_resp) begin
          w_state_nxt    = S_DONE;
          w_wb_waddr_nxt = r_waddr;
          w_wb_wdata_nxt = 32'h0;
          if (bus.bus_err) begin
            w_exc_bus_nxt  = 1'b1;
            w_exc_addr_nxt = r_addr;
          end else if (!r_we) begin
            w_wb_wdata_nxt = w_ld_data;
            w_wb_we_nxt    = r_reg_we && (r_waddr != 5'd0) && w_ld_ok;
          end
        end else if (w_tmo) begin
          w_state_nxt    = S_DONE;
          w_exc_bus_nxt  = 1'b1;
          w_exc_addr_nxt = r_addr;
        end else if (w_in_req && bus.bus_gnt) begin
          w_state_nxt = S_WAIT;
        end
      end

      default: begin
        // DONE: write-back shown this cycle; ex_req is not looked at here
        // because execute is only now advancing past the memory op.
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr   <= 32'h0;
      r_funct3 <= 3'b000;
      r_we     <= 1'b0;
      r_sel    <= 4'b0000;
      r_wdata  <= 32'h0;
      r_waddr  <= 5'd0;
      r_reg_we <= 1'b0;
    end else if (w_capture) begin
      r_addr   <= ex_addr;
      r_funct3 <= ex_funct3;
      r_we     <= ex_we;
      r_sel    <= ex_sel;
      r_wdata  <= ex_wdata;
      r_waddr  <= ex_waddr;
      r_reg_we <= ex_reg_we;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_waddr     <= 5'd0;
      wb_wdata     <= 32'h0;
      wb_we        <= 1'b0;
      exc_misalign <= 1'b0;
      exc_bus_err  <= 1'b0;
      exc_addr     <= 32'h0;
    end else begin
      wb_waddr     <= w_wb_waddr_nxt;
      wb_wdata     <= w_wb_wdata_nxt;
      wb_we        <= w_wb_we_nxt;
      exc_misalign <= w_exc_mis_nxt;
      exc_bus_err  <= w_exc_bus_nxt;
      exc_addr     <= w_exc_addr_nxt;
    end
  end

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;
  localparam int TMO   = 16;
  localparam int NEVER = 1000;
  localparam int NVEC  = 21;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        ex_req = 1'b0;
  logic        ex_we = 1'b0;
  logic [2:0]  ex_funct3 = 3'b000;
  logic [31:0] ex_addr = 32'h0;
  logic [3:0]  ex_sel = 4'h0;
  logic [31:0] ex_wdata = 32'h0;
  logic [4:0]  ex_waddr = 5'd0;
  logic        ex_reg_we = 1'b0;
  logic [31:0] ex_result = 32'h0;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        wb_we;
  logic        stall_req;
  logic        exc_misalign;
  logic        exc_bus_err;
  logic [31:0] exc_addr;
  logic [1:0]  dbg_state;

  lsu_bus_if bus_if ();

  lsu #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .ex_req(ex_req), .ex_we(ex_we), .ex_funct3(ex_funct3), .ex_addr(ex_addr),
    .ex_sel(ex_sel), .ex_wdata(ex_wdata), .ex_waddr(ex_waddr),
    .ex_reg_we(ex_reg_we), .ex_result(ex_result),
    .bus(bus_if),
    .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .wb_we(wb_we),
    .stall_req(stall_req), .exc_misalign(exc_misalign),
    .exc_bus_err(exc_bus_err), .exc_addr(exc_addr), .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [4:0]  waddr;
    logic        reg_we;
    int          g;        // cycles in REQ before grant
    int          r;        // cycles after grant until rvalid (0 = same cycle)
    logic [31:0] rdata;
    logic        err;
    logic        exp_we;
    logic        chk_data;
    logic [31:0] exp_data;
    logic        exp_mis;
    logic        exp_berr;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic drive_idle_bus();
    bus_if.bus_gnt    = 1'b0;
    bus_if.bus_rvalid = 1'b0;
    bus_if.bus_rdata  = 32'h0;
    bus_if.bus_err    = 1'b0;
  endtask

  task automatic clear_ex();
    ex_req = 1'b0; ex_we = 1'b0; ex_funct3 = 3'b000; ex_addr = 32'h0;
    ex_sel = 4'h0; ex_wdata = 32'h0; ex_waddr = 5'd0; ex_reg_we = 1'b0;
    ex_result = 32'h0;
  endtask

  // Entered and left at a negedge. Cycle 0 is the issue cycle.
  task automatic run_vec(input int id, input vec_t v);
    int gnt_c, resp_c, done_c, last_req;
    logic exp_breq;
    gnt_c  = 1 + v.g;
    resp_c = gnt_c + v.r;
    if (v.exp_mis)           done_c = 1;
    else if (resp_c <= TMO)  done_c = resp_c + 1;
    else                     done_c = TMO + 1;
    last_req = (gnt_c < TMO) ? gnt_c : TMO;

    ex_req = 1'b1; ex_we = v.we; ex_funct3 = v.f3; ex_addr = v.addr;
    ex_sel = v.sel; ex_wdata = v.wdata; ex_waddr = v.waddr; ex_reg_we = v.reg_we;
    #1;
    chk($sformatf("v%0d stall c0", id), {31'h0, stall_req}, 32'd1);
    chk($sformatf("v%0d bus_req c0", id), {31'h0, bus_if.bus_req}, 32'd0);

    for (int c = 1; c <= done_c + 1; c++) begin
      @(negedge clk);
      if (c == 1) clear_ex();
      drive_idle_bus();
      exp_breq = !v.exp_mis && (c <= gnt_c) && (c <= TMO);
      if (c < done_c) begin
        chk($sformatf("v%0d stall c%0d", id, c), {31'h0, stall_req}, 32'd1);
        chk($sformatf("v%0d bus_req c%0d", id, c), {31'h0, bus_if.bus_req}, {31'h0, exp_breq});
        if (exp_breq && (c == 1 || c == last_req)) begin
          chk($sformatf("v%0d bus_addr c%0d", id, c), bus_if.bus_addr, v.addr & 32'hFFFF_FFFC);
          chk($sformatf("v%0d bus_we c%0d", id, c), {31'h0, bus_if.bus_we}, {31'h0, v.we});
          chk($sformatf("v%0d bus_sel c%0d", id, c), {28'h0, bus_if.bus_sel}, {28'h0, v.sel});
          chk($sformatf("v%0d bus_wdata c%0d", id, c), bus_if.bus_wdata, v.wdata);
        end
      end else if (c == done_c) begin
        chk($sformatf("v%0d done state", id), {30'h0, dbg_state}, 32'd3);
        chk($sformatf("v%0d done stall", id), {31'h0, stall_req}, 32'd0);
        chk($sformatf("v%0d done bus_req", id), {31'h0, bus_if.bus_req}, 32'd0);
        chk($sformatf("v%0d wb_we", id), {31'h0, wb_we}, {31'h0, v.exp_we});
        chk($sformatf("v%0d exc_misalign", id), {31'h0, exc_misalign}, {31'h0, v.exp_mis});
        chk($sformatf("v%0d exc_bus_err", id), {31'h0, exc_bus_err}, {31'h0, v.exp_berr});
        if (v.exp_mis || v.exp_berr)
          chk($sformatf("v%0d exc_addr", id), exc_addr, v.addr);
        if (v.exp_we)
          chk($sformatf("v%0d wb_waddr", id), {27'h0, wb_waddr}, {27'h0, v.waddr});
        if (v.chk_data)
          chk($sformatf("v%0d wb_wdata", id), wb_wdata, v.exp_data);
      end else begin
        chk($sformatf("v%0d after state", id), {30'h0, dbg_state}, 32'd0);
        chk($sformatf("v%0d after wb_we", id), {31'h0, wb_we}, 32'd0);
        chk($sformatf("v%0d after exc", id), {30'h0, exc_misalign, exc_bus_err}, 32'd0);
      end
      if (c == gnt_c && !v.exp_mis && c <= TMO) bus_if.bus_gnt = 1'b1;
      if (c == resp_c && !v.exp_mis && c <= TMO) begin
        bus_if.bus_rvalid = 1'b1;
        bus_if.bus_rdata  = v.rdata;
        bus_if.bus_err    = v.err;
      end
    end
    drive_idle_bus();
  endtask

  // ---------------- main ----------------
  initial begin
    vec_t v;
    //            we   f3      addr          sel      wdata         wa    rwe  g      r      rdata         err  ewe  chk  edata         mis  berr
    vecs[0]  = '{1'b0, 3'b000, 32'h0000_0103, 4'b1000, 32'h0,        5'd7,  1'b1, 2,     1,     32'h80FF_1122, 1'b0, 1'b1, 1'b1, 32'hFFFF_FF80, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 3'b100, 32'h0000_0103, 4'b1000, 32'h0,        5'd8,  1'b1, 0,     0,     32'h80FF_1122, 1'b0, 1'b1, 1'b1, 32'h0000_0080, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 3'b000, 32'h0000_0101, 4'b0010, 32'h0,        5'd9,  1'b1, 0,     3,     32'h80FF_1122, 1'b0, 1'b1, 1'b1, 32'h0000_0011, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 3'b001, 32'h0000_0102, 4'b1100, 32'h0,        5'd10, 1'b1, 1,     2,     32'h80FF_1122, 1'b0, 1'b1, 1'b1, 32'hFFFF_80FF, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 3'b101, 32'h0000_0100, 4'b0011, 32'h0,        5'd11, 1'b1, 0,     1,     32'h1234_9ABC, 1'b0, 1'b1, 1'b1, 32'h0000_9ABC, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 3'b001, 32'h0000_0100, 4'b0011, 32'h0,        5'd12, 1'b1, 1,     0,     32'h1234_9ABC, 1'b0, 1'b1, 1'b1, 32'hFFFF_9ABC, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 3'b010, 32'h0000_0204, 4'b1111, 32'h0,        5'd31, 1'b1, 0,     1,     32'hCAFE_F00D, 1'b0, 1'b1, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 3'b010, 32'h0000_0208, 4'b1111, 32'h0,        5'd0,  1'b1, 0,     0,     32'h1111_2222, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0};
    vecs[8]  = '{1'b0, 3'b010, 32'h0000_020C, 4'b1111, 32'h0,        5'd3,  1'b0, 1,     1,     32'h3333_4444, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0};
    vecs[9]  = '{1'b1, 3'b010, 32'h0000_0200, 4'b1111, 32'hDEAD_BEEF, 5'd0,  1'b0, 0,     0,     32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0};
    vecs[10] = '{1'b1, 3'b000, 32'h0000_0203, 4'b1000, 32'h7777_7777, 5'd4,  1'b1, 3,     2,     32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0};
    vecs[11] = '{1'b0, 3'b001, 32'h0000_0101, 4'b0011, 32'h0,        5'd5,  1'b1, 0,     0,     32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0};
    vecs[12] = '{1'b1, 3'b010, 32'h0000_0202, 4'b1111, 32'h1234_5678, 5'd0,  1'b0, 0,     0,     32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0};
    vecs[13] = '{1'b0, 3'b010, 32'h0000_0103, 4'b1111, 32'h0,        5'd6,  1'b1, 0,     0,     32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0};
    vecs[14] = '{1'b0, 3'b010, 32'h0000_0300, 4'b1111, 32'h0,        5'd2,  1'b1, NEVER, 0,     32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1};
    vecs[15] = '{1'b0, 3'b010, 32'h0000_0304, 4'b1111, 32'h0,        5'd2,  1'b1, 2,     NEVER, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1};
    vecs[16] = '{1'b0, 3'b010, 32'h0000_0400, 4'b1111, 32'h0,        5'd2,  1'b1, 1,     1,     32'h0000_1234, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1};
    vecs[17] = '{1'b0, 3'b011, 32'h0000_0108, 4'b1111, 32'h0,        5'd6,  1'b1, 0,     0,     32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 32'h0,         1'b0, 1'b0};
    vecs[18] = '{1'b0, 3'b010, 32'h0000_010C, 4'b1111, 32'h0,        5'd13, 1'b1, 0,     15,    32'hA5A5_0F0F, 1'b0, 1'b1, 1'b1, 32'hA5A5_0F0F, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 3'b100, 32'h0000_0102, 4'b0100, 32'h0,        5'd14, 1'b1, 0,     2,     32'h80FF_1122, 1'b0, 1'b1, 1'b1, 32'h0000_00FF, 1'b0, 1'b0};
    vecs[20] = '{1'b0, 3'b000, 32'h0000_0100, 4'b0001, 32'h0,        5'd15, 1'b1, 2,     0,     32'h80FF_1122, 1'b0, 1'b1, 1'b1, 32'h0000_0022, 1'b0, 1'b0};

    // Reset state
    clear_ex();
    drive_idle_bus();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst bus_req", {31'h0, bus_if.bus_req}, 32'd0);
    chk("rst bus_addr", bus_if.bus_addr, 32'h0);
    chk("rst stall", {31'h0, stall_req}, 32'd0);
    chk("rst wb", {wb_we, wb_waddr, wb_wdata[25:0]}, 32'h0);
    chk("rst exc", {exc_misalign, exc_bus_err, exc_addr[29:0]}, 32'h0);
    chk("rst state", {30'h0, dbg_state}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Non-memory pass-through, back to back
    ex_result = 32'h1234; ex_waddr = 5'd5; ex_reg_we = 1'b1;
    #1 chk("pt stall", {31'h0, stall_req}, 32'd0);
    @(negedge clk);
    chk("pt1 wb_we", {31'h0, wb_we}, 32'd1);
    chk("pt1 wb_waddr", {27'h0, wb_waddr}, 32'd5);
    chk("pt1 wb_wdata", wb_wdata, 32'h1234);
    ex_result = 32'h5678; ex_waddr = 5'd6; ex_reg_we = 1'b0;
    @(negedge clk);
    chk("pt2 wb_we", {31'h0, wb_we}, 32'd0);
    chk("pt2 wb_waddr", {27'h0, wb_waddr}, 32'd6);
    chk("pt2 wb_wdata", wb_wdata, 32'h5678);
    clear_ex();
    @(negedge clk);

    // Table-driven transactions
    for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);

    // Stray rvalid in IDLE and in REQ before grant must be ignored
    bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    drive_idle_bus();
    chk("stray idle state", {30'h0, dbg_state}, 32'd0);
    chk("stray idle wb_we", {31'h0, wb_we}, 32'd0);
    ex_req = 1'b1; ex_funct3 = 3'b010; ex_addr = 32'h600; ex_sel = 4'hF;
    ex_waddr = 5'd14; ex_reg_we = 1'b1;
    @(negedge clk);
    clear_ex();
    bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = 32'hDEAD_0000;
    @(negedge clk);
    chk("stray req state", {30'h0, dbg_state}, 32'd1);
    chk("stray req bus_req", {31'h0, bus_if.bus_req}, 32'd1);
    drive_idle_bus();
    bus_if.bus_gnt = 1'b1;
    @(negedge clk);
    chk("stray wait state", {30'h0, dbg_state}, 32'd2);
    drive_idle_bus();
    bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = 32'h1357_9BDF;
    @(negedge clk);
    drive_idle_bus();
    chk("stray done wb_we", {31'h0, wb_we}, 32'd1);
    chk("stray done wb_wdata", wb_wdata, 32'h1357_9BDF);
    chk("stray done wb_waddr", {27'h0, wb_waddr}, 32'd14);
    @(negedge clk);
    chk("stray after state", {30'h0, dbg_state}, 32'd0);

    // Reset during WAIT, then a fresh LW
    ex_req = 1'b1; ex_funct3 = 3'b010; ex_addr = 32'h500; ex_sel = 4'hF;
    ex_waddr = 5'd9; ex_reg_we = 1'b1;
    @(negedge clk);
    clear_ex();
    bus_if.bus_gnt = 1'b1;
    @(negedge clk);
    drive_idle_bus();
    chk("mid wait state", {30'h0, dbg_state}, 32'd2);
    chk("mid wait stall", {31'h0, stall_req}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid rst bus_req", {31'h0, bus_if.bus_req}, 32'd0);
    chk("mid rst stall", {31'h0, stall_req}, 32'd0);
    chk("mid rst wb_we", {31'h0, wb_we}, 32'd0);
    chk("mid rst state", {30'h0, dbg_state}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    v = vecs[6];
    v.addr = 32'h0000_0504; v.waddr = 5'd21; v.rdata = 32'h0BAD_CAFE; v.exp_data = 32'h0BAD_CAFE;
    v.g = 1; v.r = 1;
    run_vec(100, v);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
